// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_pkg
//  Description : Shared types and constants for the LED sequencing controller.
//                - mode_t       : display mode encoding, also driven on mode_o
//                - LED_W        : width of the LED bank
//                - PAT_*_INIT   : pattern loaded when a mode is entered
//                - next_mode    : OFF -> BIN -> CHASE -> BOUNCE -> OFF
//                - init_pattern : initial LED pattern for a given mode
//  Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BIN    = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam logic [LED_W-1:0] PAT_BIN_INIT    = 4'b0000;
    localparam logic [LED_W-1:0] PAT_ONEHOT_INIT = 4'b0001;

    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_OFF:    n = MODE_BIN;
            MODE_BIN:    n = MODE_CHASE;
            MODE_CHASE:  n = MODE_BOUNCE;
            default:     n = MODE_OFF;
        endcase
        return n;
    endfunction

    function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
        logic [LED_W-1:0] p;
        case (m)
            MODE_CHASE, MODE_BOUNCE: p = PAT_ONEHOT_INIT;
            default:                 p = PAT_BIN_INIT;
        endcase
        return p;
    endfunction

endpackage : led_seq_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Raw push-button conditioner: 2-FF synchronizer, debounce
//                counter and rising-edge detector. A press pulse appears
//                2 + DEB_CYCLES + 1 cycles after a clean raw rising edge.
//                Releases produce no pulse.
//  Ports       : clk     - system clock
//                rst_n   - synchronous active-low reset
//                btn_raw - asynchronous raw button level
//                press   - one-cycle pulse per accepted press (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int                 c_CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_prev;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_press      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;

            // The counter only advances while the synced input disagrees
            // with the accepted level; the DEB_CYCLES-th consecutive
            // disagreeing cycle flips the level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            r_level_prev <= r_level;
            r_press      <= r_level & ~r_level_prev;
        end
    end

    assign press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : LED bank sequencer. A prescaler produces a step strobe every
//                TICK_DIV cycles; each step advances the LED pattern of the
//                current mode (OFF / BIN / CHASE / BOUNCE). A mode button
//                cycles the mode, a pause button freezes stepping.
//  Ports       : clk       - system clock
//                rst_n     - synchronous active-low reset
//                btn_mode  - raw mode button (advance mode per press)
//                btn_pause - raw pause button (toggle pause per press)
//                led       - registered LED pattern
//                mode_o    - current mode (mode_t encoding)
//                paused_o  - high while stepping is frozen
//                tick_o    - one-cycle step strobe (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_mode,
    input  logic             btn_pause,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode_o,
    output logic             paused_o,
    output logic             tick_o
);

    localparam int                 c_DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [LED_W-1:0]   c_LED_ONE  = LED_W'(1);

    logic w_mode_press;
    logic w_pause_press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_mode),
        .press   (w_mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_pause),
        .press   (w_pause_press)
    );

    mode_t              r_mode;
    mode_t              w_mode_nxt;
    logic [LED_W-1:0]   r_led;
    logic [LED_W-1:0]   w_led_nxt;
    logic               r_dir_up;
    logic               w_dir_nxt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic               r_paused;
    logic               w_paused_nxt;
    logic               r_tick;
    logic               w_tick_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode    <= MODE_OFF;
            r_led     <= '0;
            r_dir_up  <= 1'b1;
            r_div_cnt <= '0;
            r_paused  <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_led     <= w_led_nxt;
            r_dir_up  <= w_dir_nxt;
            r_div_cnt <= w_div_nxt;
            r_paused  <= w_paused_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_led_nxt    = r_led;
        w_dir_nxt    = r_dir_up;
        w_div_nxt    = r_div_cnt;
        w_paused_nxt = r_paused ^ w_pause_press;

        if (w_mode_press) begin
            // A mode change overrides any step due in this cycle and
            // restarts the prescaler so the first step is a full period away.
            w_mode_nxt = next_mode(r_mode);
            w_led_nxt  = init_pattern(w_mode_nxt);
            w_dir_nxt  = 1'b1;
            w_div_nxt  = '0;
        end else if (r_tick) begin
            // r_tick is only ever set when unpaused with the prescaler at its
            // last count, so it doubles as the step enable.
            w_div_nxt = '0;
            case (r_mode)
                MODE_OFF:   w_led_nxt = '0;
                MODE_BIN:   w_led_nxt = r_led + c_LED_ONE;
                MODE_CHASE: w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
                MODE_BOUNCE: begin
                    // Direction flips on reaching an end so the endpoint is
                    // shown once, not twice.
                    if (r_dir_up) begin
                        w_led_nxt = r_led << 1;
                        if (w_led_nxt[LED_W-1]) begin
                            w_dir_nxt = 1'b0;
                        end
                    end else begin
                        w_led_nxt = r_led >> 1;
                        if (w_led_nxt[0]) begin
                            w_dir_nxt = 1'b1;
                        end
                    end
                end
                default:    w_led_nxt = '0;
            endcase
        end else if (!r_paused) begin
            w_div_nxt = r_div_cnt + c_DIV_ONE;
        end

        // Strobe is computed from next-state so it is high exactly in the
        // cycle where the prescaler sits at its last count while running.
        w_tick_nxt = (w_div_nxt == c_DIV_LAST) && !w_paused_nxt;
    end

    assign led      = r_led;
    assign mode_o   = r_mode;
    assign paused_o = r_paused;
    assign tick_o   = r_tick;

endmodule : led_seq_ctrl
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_seq_ctrl
//  Description : Self-checking bench for led_seq_ctrl with TICK_DIV=4 and
//                DEB_CYCLES=3. A per-cycle vector table covers reset release
//                and the first mode press through a full BIN wrap; directed
//                sequences cover bounce rejection, BOUNCE walk, pause/resume,
//                simultaneous presses and mid-pattern reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int c_TICK_DIV   = 4;
    localparam int c_DEB_CYCLES = 3;
    localparam int c_NVEC       = 79;

    logic       clk;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_pause;
    logic [3:0] led;
    logic [1:0] mode_o;
    logic       paused_o;
    logic       tick_o;

    int n_vec;
    int n_bad;

    led_seq_ctrl #(
        .TICK_DIV   (c_TICK_DIV),
        .DEB_CYCLES (c_DEB_CYCLES)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_pause (btn_pause),
        .led       (led),
        .mode_o    (mode_o),
        .paused_o  (paused_o),
        .tick_o    (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       bm;
        logic [3:0] led;
        logic [1:0] mode;
        logic       paused;
        logic       tick;
    } vec_t;

    vec_t       tbl   [1:c_NVEC];
    logic [3:0] bseq  [1:7];

    // mask bits: [3] led, [2] mode, [1] paused, [0] tick
    task automatic check(input string name, input logic [3:0] mask,
                         input logic [3:0] el, input logic [1:0] em,
                         input logic ep, input logic et);
        logic bad;
        bad = (mask[3] && (led      !== el)) ||
              (mask[2] && (mode_o   !== em)) ||
              (mask[1] && (paused_o !== ep)) ||
              (mask[0] && (tick_o   !== et));
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got led=%b mode=%0d paused=%b tick=%b, expected led=%b mode=%0d paused=%b tick=%b (mask %b)",
                     name, led, mode_o, paused_o, tick_o, el, em, ep, et, mask);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw button(s) held for 7 cycles: the press takes effect on the 7th edge.
    task automatic press(input logic m, input logic p);
        btn_mode  = m;
        btn_pause = p;
        cycles(7);
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tick_seen;
        n_vec = 0;
        n_bad = 0;

        // Per-cycle table, index i = outputs after the i-th edge following
        // reset release. Mode raw is high for edges 9..18; the press lands on
        // edge 15, after which BIN steps every 4 edges starting at 19.
        for (int i = 1; i <= c_NVEC; i++) begin
            tbl[i].bm     = (i >= 9) && (i <= 18);
            tbl[i].paused = 1'b0;
            if (i <= 14) begin
                tbl[i].mode = 2'd0;
                tbl[i].led  = 4'b0000;
                tbl[i].tick = ((i % 4) == 3);
            end else begin
                tbl[i].mode = 2'd1;
                tbl[i].led  = 4'(((i - 15) / 4) % 16);
                tbl[i].tick = (i >= 16) && (((i - 15) % 4) == 3);
            end
        end
        bseq[1] = 4'b0010; bseq[2] = 4'b0100; bseq[3] = 4'b1000; bseq[4] = 4'b0100;
        bseq[5] = 4'b0010; bseq[6] = 4'b0001; bseq[7] = 4'b0010;

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
        cycles(3);
        check("reset_state", 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 1; i <= c_NVEC; i++) begin
            btn_mode = tbl[i].bm;
            @(negedge clk);
            check($sformatf("vec%0d", i), 4'b1111, tbl[i].led, tbl[i].mode,
                  tbl[i].paused, tbl[i].tick);
        end

        // ---------------- bounce rejection ----------------
        for (int j = 0; j < 20; j++) begin
            btn_mode = (((j / 2) % 2) == 0);
            @(negedge clk);
        end
        btn_mode = 1'b0;
        cycles(10);
        check("bounce_reject", 4'b0110, 4'b0000, 2'd1, 1'b0, 1'b0);

        // ---------------- BIN -> CHASE -> BOUNCE walk ----------------
        press(1'b1, 1'b0);
        check("to_chase", 4'b1110, 4'b0001, 2'd2, 1'b0, 1'b0);
        cycles(8);
        press(1'b1, 1'b0);
        check("to_bounce", 4'b1111, 4'b0001, 2'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            cycles(4);
            check($sformatf("bounce_step%0d", k), 4'b1100, bseq[k], 2'd3, 1'b0, 1'b0);
        end

        press(1'b1, 1'b0);
        check("to_off", 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0);
        cycles(8);
        check("off_holds", 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        check("to_bin", 4'b1110, 4'b0000, 2'd1, 1'b0, 1'b0);
        cycles(8);

        // ---------------- pause in CHASE at 0100 ----------------
        press(1'b1, 1'b0);
        check("to_chase2", 4'b1111, 4'b0001, 2'd2, 1'b0, 1'b0);
        cycles(3);
        press(1'b0, 1'b1);           // pause lands 10 edges after CHASE entry, div held at 2
        check("paused", 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tick_o !== 1'b0) tick_seen++;
        end
        n_vec++;
        if (tick_seen != 0) begin
            n_bad++;
            $display("FAIL pause_no_tick: got %0d tick cycles while paused, expected 0", tick_seen);
        end
        check("pause_hold", 4'b1110, 4'b0100, 2'd2, 1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("unpaused", 4'b1111, 4'b0100, 2'd2, 1'b0, 1'b0);
        cycles(1);
        check("resume_tick", 4'b1111, 4'b0100, 2'd2, 1'b0, 1'b1);
        cycles(1);
        check("resume_step", 4'b1111, 4'b1000, 2'd2, 1'b0, 1'b0);

        // ---------------- mode + pause together ----------------
        cycles(8);
        press(1'b1, 1'b1);
        check("both_press", 4'b1111, 4'b0001, 2'd3, 1'b1, 1'b0);
        cycles(10);
        check("both_hold", 4'b1111, 4'b0001, 2'd3, 1'b1, 1'b0);

        // ---------------- mode while paused, then BIN to 1010, reset ----------------
        press(1'b1, 1'b0);
        check("paused_to_off", 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0);
        cycles(8);
        press(1'b1, 1'b0);
        check("paused_to_bin", 4'b1111, 4'b0000, 2'd1, 1'b1, 1'b0);
        cycles(8);
        press(1'b0, 1'b1);
        check("bin_unpause", 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0);
        cycles(41);
        check("bin_1010", 4'b1111, 4'b1010, 2'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        cycles(1);
        check("mid_reset", 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        check("post_reset_notick", 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        cycles(1);
        check("post_reset_tick", 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_led_seq_ctrl
`default_nettype wire
